// File: rtl/binary_gray_counter_mpc_if.sv
// Handshake bundle between the Gray-code producer and its consumer.
// The master side is the counter; the slave side drives the controls and accepts codes.
interface binary_gray_counter_mpc_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] bin_in;
  logic             en;
  logic             up;
  logic             out_ready;
  logic [WIDTH-1:0] GRAY;
  logic [WIDTH-1:0] bin_q;
  logic             out_valid;
  logic             wrap;

  modport master (
    input  load, bin_in, en, up, out_ready,
    output GRAY, bin_q, out_valid, wrap
  );

  modport slave (
    output load, bin_in, en, up, out_ready,
    input  GRAY, bin_q, out_valid, wrap
  );
endinterface

// File: rtl/binary_gray_counter_mpc.sv
// Up/down binary counter with a registered Gray-code view on a valid/ready output.
// load always wins; a step is taken only while the held code is not stalled.
module binary_gray_counter_mpc #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  binary_gray_counter_mpc_if.master bus
);
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_r, gray_r, bin_step;
  logic             wrap_r, stall, step_ok, step_wraps;

  assign stall      = bus.out_valid & ~bus.out_ready;
  assign step_ok    = bus.en & ~bus.load & ~stall;
  assign bin_step   = bus.up ? bin_r + 1'b1 : bin_r - 1'b1;
  assign step_wraps = bus.up ? (&bin_r) : ~(|bin_r);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.load || step_ok)
      state_nxt = PRESENT;
    else if (state == PRESENT && bus.out_ready)
      state_nxt = IDLE;
  end

  always_comb begin
    bus.out_valid = (state == PRESENT);
    bus.GRAY      = gray_r;
    bus.bin_q     = bin_r;
    bus.wrap      = wrap_r;
  end

  // Gray is encoded from the next binary value so both land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r  <= '0;
      gray_r <= '0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      bin_r  <= bus.bin_in;
      gray_r <= bus.bin_in ^ (bus.bin_in >> 1);
      wrap_r <= 1'b0;
    end else if (step_ok) begin
      bin_r  <= bin_step;
      gray_r <= bin_step ^ (bin_step >> 1);
      wrap_r <= step_wraps;
    end else begin
      wrap_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_binary_gray_counter_mpc.sv
// Directed checks of load, up/down counting, wrap pulses, stall hold and reset.
module tb_binary_gray_counter_mpc;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  binary_gray_counter_mpc_if #(.WIDTH(WIDTH)) bus ();
  binary_gray_counter_mpc #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] bi, input logic e, input logic u, input logic rdy);
    bus.load = ld; bus.bin_in = bi; bus.en = e; bus.up = u; bus.out_ready = rdy;
  endtask

  task automatic expect4(input string tag, input logic [3:0] g, input logic [3:0] b,
                         input logic v, input logic w);
    chk({tag, ".gray"}, bus.GRAY, g);
    chk({tag, ".bin"},  bus.bin_q, b);
    chk({tag, ".vld"},  bus.out_valid, v);
    chk({tag, ".wrap"}, bus.wrap, w);
  endtask

  initial begin
    logic [3:0] prev;
    rst = 1'b1;
    drive(1'b1, 4'b1010, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    expect4("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
      tick();
      expect4($sformatf("load%0d", i), gtab[i], 4'(i), 1'b1, 1'b0);
    end

    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    prev = bus.GRAY;
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      expect4($sformatf("up%0d", k), gtab[k % 16], 4'(k % 16), 1'b1, k == 16);
      chk($sformatf("up%0d.onebit", k), $countones(prev ^ bus.GRAY), 1);
      prev = bus.GRAY;
    end

    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    expect4("dn_wrap", 4'b1000, 4'b1111, 1'b1, 1'b1);
    tick();
    expect4("dn_next", 4'b1001, 4'b1110, 1'b1, 1'b0);

    drive(1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
    tick();
    expect4("stall_ld", 4'b0011, 4'b0010, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect4($sformatf("stall%0d", k), 4'b0011, 4'b0010, 1'b1, 1'b0);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    expect4("unstall", 4'b0010, 4'b0011, 1'b1, 1'b0);
    drive(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0);
    tick();
    expect4("ld_stall", 4'b1010, 4'b1100, 1'b1, 1'b0);

    drive(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
    tick();
    expect4("ld_en", 4'b0111, 4'b0101, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    expect4("to_idle", 4'b0111, 4'b0101, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    expect4("idle_en", 4'b0101, 4'b0110, 1'b1, 1'b0);
    tick();
    expect4("hold", 4'b0101, 4'b0110, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
    tick();
    expect4("rst_stall", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    expect4("post_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
